id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/arm_pkg.sv | 103 ++++++++++
 rtl/register_file.sv | 38 +++
 rtl/id_stage.sv | 187 ++++++++++++++++++
 tb/tb_id_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Purpose: shared ARM decode constants (opcode, exe_cmd, cond, mode), the
// ID/EX payload struct and the condition-code evaluator. The execute stage
// imports the same definitions.
package arm_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 4;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned SHOP_W = 12;
    localparam int unsigned IMM24_W = 24;
    localparam int unsigned NREGS  = 16;

    // Instruction modes, bits [27:26]
    localparam logic [1:0] MODE_ARITH  = 2'b00;
    localparam logic [1:0] MODE_MEM    = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;

    // Data-processing opcodes, bits [24:21]
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // ALU commands consumed by the execute stage
    localparam logic [CMD_W-1:0] EXE_NOP = 4'b0000;
    localparam logic [CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] EXE_EOR = 4'b1000;
    localparam logic [CMD_W-1:0] EXE_MVN = 4'b1001;

    // Condition field, bits [31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // ID/EX pipeline register payload
    typedef struct packed {
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  val_rn;
        logic [DATA_W-1:0]  val_rm;
        logic [CMD_W-1:0]   exe_cmd;
        logic               mem_r_en;
        logic               mem_w_en;
        logic               wb_en;
        logic               b;
        logic               s;
        logic               imm;
        logic [REG_AW-1:0]  dest;
        logic [SHOP_W-1:0]  shift_operand;
        logic [IMM24_W-1:0] signed_imm_24;
    } id_ex_t;

    // Evaluates an ARM condition against {N,Z,C,V}; NV never executes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return c;
            COND_CC: return ~c;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return c & ~z;
            COND_LS: return ~c | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            COND_AL: return 1'b1;
            COND_NV: return 1'b0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/register_file.sv
// Purpose: 16x32 register file, two combinational read ports, one write port
// written on the falling clock edge so a same-cycle write is visible to the
// rising-edge ID/EX capture.
// Ports: clk, rst (async, active-high, clears all registers);
//        i_ra1/i_ra2 read addresses, o_rd1/o_rd2 read data;
//        i_we/i_wa/i_wd write enable, address, data.
module register_file
    import arm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_ra1,
    input  logic [REG_AW-1:0] i_ra2,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2
);

    logic [DATA_W-1:0] r_regs [NREGS];

    // Falling-edge write; reset also discards a write pending in the same cycle
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // R15 returns its stored value; no PC substitution here
    assign o_rd1 = r_regs[i_ra1];
    assign o_rd2 = r_regs[i_ra2];

endmodule

// File: rtl/id_stage.sv
// Purpose: ARM instruction decode stage. Decodes the fetched word, checks its
// condition against NZCV, reads operands and registers everything into the
// ID/EX register on the rising clock edge.
// Ports: clk, rst (async, active-high);
//        pc_in, instruction_in from fetch; hazard (bubble), flush (kill);
//        status_in {N,Z,C,V}; wb_en_in/wb_dest/wb_value write-back port;
//        registered outputs pc_out, val_rn, val_rm, exe_cmd, mem_r_en,
//        mem_w_en, wb_en, b, s, imm, dest, shift_operand, signed_imm_24;
//        combinational src1, src2, two_src to the hazard unit.
module id_stage
    import arm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  pc_in,
    input  logic [DATA_W-1:0]  instruction_in,
    input  logic               hazard,
    input  logic               flush,
    input  logic [3:0]         status_in,
    input  logic               wb_en_in,
    input  logic [REG_AW-1:0]  wb_dest,
    input  logic [DATA_W-1:0]  wb_value,
    output logic [DATA_W-1:0]  pc_out,
    output logic [DATA_W-1:0]  val_rn,
    output logic [DATA_W-1:0]  val_rm,
    output logic [CMD_W-1:0]   exe_cmd,
    output logic               mem_r_en,
    output logic               mem_w_en,
    output logic               wb_en,
    output logic               b,
    output logic               s,
    output logic               imm,
    output logic [REG_AW-1:0]  dest,
    output logic [SHOP_W-1:0]  shift_operand,
    output logic [IMM24_W-1:0] signed_imm_24,
    output logic [REG_AW-1:0]  src1,
    output logic [REG_AW-1:0]  src2,
    output logic               two_src
);

    // Instruction fields
    logic [3:0]        w_cond;
    logic [1:0]        w_mode;
    logic              w_i_bit;
    logic [3:0]        w_opcode;
    logic              w_s_bit;
    logic [REG_AW-1:0] w_rn;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rm;

    assign w_cond   = instruction_in[31:28];
    assign w_mode   = instruction_in[27:26];
    assign w_i_bit  = instruction_in[25];
    assign w_opcode = instruction_in[24:21];
    assign w_s_bit  = instruction_in[20];
    assign w_rn     = instruction_in[19:16];
    assign w_rd     = instruction_in[15:12];
    assign w_rm     = instruction_in[3:0];

    // Raw decode, before condition/hazard gating
    logic [CMD_W-1:0] w_cmd;
    logic             w_mem_r;
    logic             w_mem_w_dec;
    logic             w_wb;
    logic             w_b;
    logic             w_s;

    always_comb begin
        w_cmd       = EXE_NOP;
        w_mem_r     = 1'b0;
        w_mem_w_dec = 1'b0;
        w_wb        = 1'b0;
        w_b         = 1'b0;
        w_s         = 1'b0;
        case (w_mode)
            MODE_ARITH: begin
                w_s  = w_s_bit;
                w_wb = 1'b1;
                case (w_opcode)
                    OP_MOV:  w_cmd = EXE_MOV;
                    OP_MVN:  w_cmd = EXE_MVN;
                    OP_ADD:  w_cmd = EXE_ADD;
                    OP_ADC:  w_cmd = EXE_ADC;
                    OP_SUB:  w_cmd = EXE_SUB;
                    OP_SBC:  w_cmd = EXE_SBC;
                    OP_AND:  w_cmd = EXE_AND;
                    OP_ORR:  w_cmd = EXE_ORR;
                    OP_EOR:  w_cmd = EXE_EOR;
                    OP_CMP: begin
                        w_cmd = EXE_SUB;
                        w_wb  = 1'b0;
                    end
                    OP_TST: begin
                        w_cmd = EXE_AND;
                        w_wb  = 1'b0;
                    end
                    default: w_wb = 1'b0;
                endcase
            end
            MODE_MEM: begin
                // S selects LDR (1) or STR (0); address is always Rn + offset
                w_cmd = EXE_ADD;
                if (w_s_bit) begin
                    w_mem_r = 1'b1;
                    w_wb    = 1'b1;
                end else begin
                    w_mem_w_dec = 1'b1;
                end
            end
            MODE_BRANCH: w_b = 1'b1;
            default: ;
        endcase
    end

    // Hazard-unit sources: a store reads Rd as its data operand
    assign src1    = w_rn;
    assign src2    = w_mem_w_dec ? w_rd : w_rm;
    assign two_src = ~w_i_bit | w_mem_w_dec;

    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    register_file u_register_file (
        .clk   (clk),
        .rst   (rst),
        .i_ra1 (w_rn),
        .i_ra2 (src2),
        .i_we  (wb_en_in),
        .i_wa  (wb_dest),
        .i_wd  (wb_value),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    // Control is killed by a failed condition or a stall; datapath still flows
    logic   w_ctrl_en;
    id_ex_t w_next;

    assign w_ctrl_en = cond_pass(w_cond, status_in) & ~hazard;

    always_comb begin
        w_next               = '0;
        w_next.pc            = pc_in;
        w_next.val_rn        = w_rd1;
        w_next.val_rm        = w_rd2;
        w_next.imm           = w_i_bit;
        w_next.dest          = w_rd;
        w_next.shift_operand = instruction_in[11:0];
        w_next.signed_imm_24 = instruction_in[23:0];
        if (w_ctrl_en) begin
            w_next.exe_cmd  = w_cmd;
            w_next.mem_r_en = w_mem_r;
            w_next.mem_w_en = w_mem_w_dec;
            w_next.wb_en    = w_wb;
            w_next.b        = w_b;
            w_next.s        = w_s;
        end
    end

    // ID/EX register; flush wins over hazard and clears every field
    id_ex_t r_id_ex;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_ex <= '0;
        end else if (flush) begin
            r_id_ex <= '0;
        end else begin
            r_id_ex <= w_next;
        end
    end

    assign pc_out        = r_id_ex.pc;
    assign val_rn        = r_id_ex.val_rn;
    assign val_rm        = r_id_ex.val_rm;
    assign exe_cmd       = r_id_ex.exe_cmd;
    assign mem_r_en      = r_id_ex.mem_r_en;
    assign mem_w_en      = r_id_ex.mem_w_en;
    assign wb_en         = r_id_ex.wb_en;
    assign b             = r_id_ex.b;
    assign s             = r_id_ex.s;
    assign imm           = r_id_ex.imm;
    assign dest          = r_id_ex.dest;
    assign shift_operand = r_id_ex.shift_operand;
    assign signed_imm_24 = r_id_ex.signed_imm_24;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: the driver pushes the expected ID/EX contents
// computed by a behavioural ARM decode model; a monitor pops and compares one
// rising edge later.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = '0, instruction_in = '0;
    logic        hazard = 1'b0, flush = 1'b0;
    logic [3:0]  status_in = '0;
    logic        wb_en_in = 1'b0;
    logic [3:0]  wb_dest = '0;
    logic [31:0] wb_value = '0;
    logic [31:0] pc_out, val_rn, val_rm;
    logic [3:0]  exe_cmd, dest, src1, src2;
    logic        mem_r_en, mem_w_en, wb_en, b, s, imm, two_src;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;

    id_stage dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instruction_in(instruction_in),
        .hazard(hazard), .flush(flush), .status_in(status_in),
        .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
        .pc_out(pc_out), .val_rn(val_rn), .val_rm(val_rm), .exe_cmd(exe_cmd),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .b(b), .s(s),
        .imm(imm), .dest(dest), .shift_operand(shift_operand),
        .signed_imm_24(signed_imm_24), .src1(src1), .src2(src2), .two_src(two_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, rn, rm;
        logic [3:0]  cmd;
        logic        mr, mw, wb, br, s, imm;
        logic [3:0]  dest;
        logic [11:0] sh;
        logic [23:0] si;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mregs [16];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [145:0] act, input logic [145:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [145:0] dut_vec();
        return {pc_out, val_rn, val_rm, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s,
                imm, dest, shift_operand, signed_imm_24};
    endfunction

    function automatic logic [145:0] exp_vec(input exp_t e);
        return {e.pc, e.rn, e.rm, e.cmd, e.mr, e.mw, e.wb, e.br, e.s, e.imm,
                e.dest, e.sh, e.si};
    endfunction

    // Conditions come in complementary pairs: odd code = negation of even code
    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] st);
        logic n, z, c, v, base;
        {n, z, c, v} = st;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] ins,
                                        input logic haz, input logic fl, input logic [3:0] st);
        exp_t       e;
        logic [1:0] mode;
        logic [3:0] op;
        logic       is_str;
        e = '{default: '0};
        if (fl) return e;
        mode   = ins[27:26];
        op     = ins[24:21];
        is_str = (mode == 2'd1) && !ins[20];
        e.pc   = pc;
        e.rn   = mregs[ins[19:16]];
        e.rm   = is_str ? mregs[ins[15:12]] : mregs[ins[3:0]];
        e.imm  = ins[25];
        e.dest = ins[15:12];
        e.sh   = ins[11:0];
        e.si   = ins[23:0];
        if (mode == 2'd0) begin
            e.s  = ins[20];
            e.wb = 1'b1;
            case (op)
                4'hD: e.cmd = 4'h1;   // MOV
                4'hF: e.cmd = 4'h9;   // MVN
                4'h4: e.cmd = 4'h2;   // ADD
                4'h5: e.cmd = 4'h3;   // ADC
                4'h2: e.cmd = 4'h4;   // SUB
                4'h6: e.cmd = 4'h5;   // SBC
                4'h0: e.cmd = 4'h6;   // AND
                4'hC: e.cmd = 4'h7;   // ORR
                4'h1: e.cmd = 4'h8;   // EOR
                4'hA: begin e.cmd = 4'h4; e.wb = 1'b0; end  // CMP
                4'h8: begin e.cmd = 4'h6; e.wb = 1'b0; end  // TST
                default: e.wb = 1'b0;
            endcase
        end else if (mode == 2'd1) begin
            e.cmd = 4'h2;
            e.mr  = ins[20];
            e.wb  = ins[20];
            e.mw  = !ins[20];
        end else if (mode == 2'd2) begin
            e.br = 1'b1;
        end
        if (!cond_ok(ins[31:28], st) || haz) begin
            e.cmd = '0; e.mr = 0; e.mw = 0; e.wb = 0; e.br = 0; e.s = 0;
        end
        return e;
    endfunction

    // Called at posedge+2: applies inputs, updates model, checks hazard-unit outputs
    task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic haz,
                         input logic fl, input logic [3:0] st, input logic wbe,
                         input logic [3:0] wbd, input logic [31:0] wbv);
        logic is_str;
        pc_in = pc; instruction_in = ins; hazard = haz; flush = fl; status_in = st;
        wb_en_in = wbe; wb_dest = wbd; wb_value = wbv;
        if (wbe) mregs[wbd] = wbv;   // lands on the falling edge before capture
        sb_q.push_back(ref_decode(pc, ins, haz, fl, st));
        #1;
        is_str = (ins[27:26] == 2'd1) && !ins[20];
        chk("src", 146'({src1, src2, two_src}),
            146'({ins[19:16], is_str ? ins[15:12] : ins[3:0], !ins[25] || is_str}));
    endtask

    task automatic go(input logic [31:0] pc, input logic [31:0] ins, input logic haz,
                      input logic fl, input logic [3:0] st, input logic wbe,
                      input logic [3:0] wbd, input logic [31:0] wbv);
        @(posedge clk); #2;
        drive(pc, ins, haz, fl, st, wbe, wbd, wbv);
    endtask

    task automatic probe();
        @(posedge clk); #1;
    endtask

    // Reset pulse held across a falling edge with a write pending; then one issue
    task automatic reset_pulse(input logic [31:0] pc, input logic [31:0] ins);
        @(posedge clk); #2;
        rst = 1'b1; wb_en_in = 1'b1; wb_dest = 4'd5; wb_value = 32'hDEAD_BEEF;
        #1;
        chk("rst_outputs", dut_vec(), '0);
        #4;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        sb_q.delete();
        drive(pc, ins, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 32'd0);
    endtask

    // Monitor: compare each capture against the scoreboard
    initial begin
        forever begin
            @(posedge clk); #1;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("idex", dut_vec(), exp_vec(e));
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", dut_vec(), '0);
        #1 rst = 1'b0;

        // MOV R0,#20
        drive(32'h4, 32'hE3A00014, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 32'd0);
        probe();
        chk("mov", 146'({exe_cmd, imm, wb_en, dest, shift_operand}),
            146'({4'b0001, 1'b1, 1'b1, 4'd0, 12'h014}));
        // ADDNE with Z=1 fails, Z=0 passes
        #1 drive(32'h8, 32'h10811001, 1'b0, 1'b0, 4'b0100, 1'b0, 4'd0, 32'd0);
        probe();
        chk("addne_z1", 146'({exe_cmd, mem_r_en, mem_w_en, wb_en, b, s}), '0);
        #1 drive(32'hC, 32'h10811001, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 32'd0);
        probe();
        chk("addne_z0", 146'({exe_cmd, wb_en}), 146'({4'b0010, 1'b1}));
        // Same-cycle write of R5 and read through Rm
        #1 drive(32'h10, 32'hE0245005, 1'b0, 1'b0, 4'b0000, 1'b1, 4'd5, 32'hFFFFFF85);
        probe();
        chk("wb_bypass", 146'(val_rm), 146'(32'hFFFFFF85));
        // STR R1,[R0]
        #1 drive(32'h14, 32'hE4801000, 1'b0, 1'b0, 4'b0000, 1'b1, 4'd15, 32'h1234_5678);
        probe();
        chk("str", 146'({mem_w_en, wb_en}), 146'({1'b1, 1'b0}));
        // Flush with hazard, then hazard alone
        #1 drive(32'h18, 32'hE3A00014, 1'b1, 1'b1, 4'b0000, 1'b0, 4'd0, 32'd0);
        probe();
        chk("flush_hazard", dut_vec(), '0);
        #1 drive(32'h100, 32'hE3A00014, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0, 32'd0);
        probe();
        chk("hazard_only", 146'({pc_out, exe_cmd, wb_en}), 146'({32'h100, 4'd0, 1'b0}));
        // R15 readback returns stored value
        #1 drive(32'h104, 32'hE08F100F, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 32'd0);
        probe();
        chk("r15_read", 146'({val_rn, val_rm}), 146'({32'h1234_5678, 32'h1234_5678}));
        // Reset clears registers, including the write pending during reset
        reset_pulse(32'h200, 32'hE0245005);
        probe();
        chk("post_rst_regs", 146'({val_rn, val_rm}), '0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic [1:0]  mode;
            int          sel;
            if (n % 100 == 99) begin
                reset_pulse($urandom, $urandom);
                continue;
            end
            ins = $urandom;
            sel = $urandom_range(0, 9);
            mode = (sel < 5) ? 2'd0 : (sel < 8) ? 2'd1 : (sel == 8) ? 2'd2 : 2'd3;
            ins[27:26] = mode;
            if ($urandom_range(0, 1) == 1) ins[31:28] = 4'b1110;
            go($urandom, ins, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
               4'($urandom), 1'($urandom), 4'($urandom), $urandom);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 146'(sb_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
